imm_ext_pipe: RTL and testbench



---
 rtl/imm_ext_pkg.sv | 20 ++
 rtl/imm_ext_skid.sv | 74 +++++++
 rtl/imm_ext_pipe.sv | 65 ++++++
 tb/tb_imm_ext_pipe.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/imm_ext_pkg.sv
// Shared definitions for the registered immediate/data extension unit:
// mode encodings and the skid-buffer occupancy states.
package imm_ext_pkg;

    typedef logic [2:0] mode_t;

    localparam mode_t MODE_ZERO      = 3'd0;
    localparam mode_t MODE_SIGN      = 3'd1;
    localparam mode_t MODE_UPPER     = 3'd2;
    localparam mode_t MODE_BRANCH    = 3'd3;
    localparam mode_t MODE_BYTE_SIGN = 3'd4;
    localparam mode_t MODE_BYTE_ZERO = 3'd5;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/imm_ext_skid.sv
// Generic 2-entry valid/ready skid buffer. The main entry drives the output;
// the skid entry catches one extra beat so in_ready can be a pure register.
module imm_ext_skid
    import imm_ext_pkg::*;
#(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    skid_state_e  state_q, state_d;
    logic [W-1:0] m_q, m_d, s_q, s_d;
    logic         in_ready_q;
    logic         acc, rel;

    assign acc = in_valid_i && in_ready_q;
    assign rel = out_valid_o && out_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            m_q        <= '0;
            s_q        <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            m_q        <= m_d;
            s_q        <= s_d;
            // Looks ahead at the next state so ready never depends on out_ready combinationally
            in_ready_q <= (state_d != ST_FULL);
        end
    end

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;
        case (state_q)
            ST_EMPTY: if (acc) begin
                m_d     = in_data_i;
                state_d = ST_ONE;
            end
            ST_ONE: begin
                if (acc && rel) begin
                    m_d = in_data_i;
                end else if (acc) begin
                    s_d     = in_data_i;
                    state_d = ST_FULL;
                end else if (rel) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: if (rel) begin
                m_d     = s_q;
                state_d = ST_ONE;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        out_valid_o = (state_q != ST_EMPTY);
        out_data_o  = m_q;
        in_ready_o  = in_ready_q;
    end

endmodule

// File: rtl/imm_ext_pipe.sv
// Registered immediate/data extender: computes the extension at accept time
// and queues {err, data} through a 2-entry skid buffer (one-cycle latency).
module imm_ext_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_W     = 16,
    parameter int OUT_W    = 32,
    parameter int BR_SHIFT = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [2:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_err
);

    logic [OUT_W-1:0] zext, sext, bzext, bsext, ext;
    logic             err;
    logic [OUT_W:0]   pay_in, pay_out;

    always_comb begin
        zext             = '0;
        zext[IN_W-1:0]   = in_data;
        sext             = {OUT_W{in_data[IN_W-1]}};
        sext[IN_W-1:0]   = in_data;
        bzext            = '0;
        bzext[7:0]       = in_data[7:0];
        bsext            = {OUT_W{in_data[7]}};
        bsext[7:0]       = in_data[7:0];
        ext              = '0;
        err              = 1'b0;
        case (mode_t'(in_mode))
            MODE_ZERO:      ext = zext;
            MODE_SIGN:      ext = sext;
            MODE_UPPER:     ext = zext << (OUT_W - IN_W);
            MODE_BRANCH:    ext = sext << BR_SHIFT;
            MODE_BYTE_SIGN: ext = bsext;
            MODE_BYTE_ZERO: ext = bzext;
            default:        err = 1'b1;
        endcase
    end

    // Gate with in_valid so garbage on idle inputs never reaches the entries
    assign pay_in = in_valid ? {err, ext} : '0;

    imm_ext_skid #(.W(OUT_W + 1)) u_skid (
        .clk         (clk),
        .rst_n       (reset_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (pay_in),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (pay_out)
    );

    assign out_data = pay_out[OUT_W-1:0];
    assign out_err  = pay_out[OUT_W];

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Scoreboard bench for imm_ext_pipe: expected {err,data} queued at accept,
// popped and compared at each release.
module tb_imm_ext_pipe;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] in_data = '0;
    logic [2:0]  in_mode = '0;
    logic        in_ready, out_valid, out_err;
    logic [31:0] out_data;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_rel = 0;
    int          base;
    logic [32:0] sb[$];
    logic [32:0] mon_exp;

    imm_ext_pipe #(.IN_W(16), .OUT_W(32), .BR_SHIFT(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    function automatic logic [32:0] model(input logic [2:0] m, input logic [15:0] d);
        case (m)
            3'd0:    return {1'b0, 16'h0000, d};
            3'd1:    return {1'b0, {16{d[15]}}, d};
            3'd2:    return {1'b0, d, 16'h0000};
            3'd3:    return {1'b0, {14{d[15]}}, d, 2'b00};
            3'd4:    return {1'b0, {24{d[7]}}, d[7:0]};
            3'd5:    return {1'b0, 24'h000000, d[7:0]};
            default: return {1'b1, 32'h0};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (out_valid && out_ready) begin
                n_rel++;
                if (sb.size() == 0) chk("spurious_result", 64'd1, 64'd0);
                else begin
                    mon_exp = sb.pop_front();
                    chk("result", {31'd0, out_err, out_data}, {31'd0, mon_exp});
                end
            end
            if (in_valid && in_ready) sb.push_back(model(in_mode, in_data));
        end
    end

    // Called just after a posedge; returns just after the accepting posedge.
    task automatic send(input logic [2:0] m, input logic [15:0] d);
        int t = 0;
        in_valid = 1'b1; in_mode = m; in_data = d;
        @(negedge clk);
        while (!in_ready && t < 50) begin @(negedge clk); t++; end
        if (!in_ready) chk("send_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_mode = '0; in_data = '0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 30) begin @(posedge clk); t++; end
        #1;
        chk("drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset state
        #12;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
        chk("rst_out_data",  {32'd0, out_data},  64'd0);
        chk("rst_out_err",   {63'd0, out_err},   64'd0);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;

        // 1: sign extension, one-cycle latency
        out_ready = 1'b1;
        send(3'd1, 16'h8888);
        @(negedge clk);
        chk("lat_valid", {63'd0, out_valid}, 64'd1);
        chk("lat_data",  {32'd0, out_data},  64'hFFFF8888);
        chk("lat_err",   {63'd0, out_err},   64'd0);
        @(posedge clk); #1;
        send(3'd1, 16'h1111);
        drain();

        // 2: back-to-back ZERO / UPPER, one release per cycle
        base = n_rel;
        send(3'd0, 16'h8888);
        send(3'd2, 16'h1234);
        chk("b2b_first",  64'(n_rel - base), 64'd1);
        @(negedge clk); #1;
        chk("b2b_second", 64'(n_rel - base), 64'd2);
        @(posedge clk); #1;
        drain();

        // 3: branch and byte modes
        send(3'd3, 16'hFFFF);
        send(3'd3, 16'h0004);
        send(3'd4, 16'h0080);
        send(3'd5, 16'hFF80);
        drain();

        // 4: backpressure fills both entries and stalls the third request
        out_ready = 1'b0;
        send(3'd1, 16'h0001);
        send(3'd1, 16'h0002);
        chk("bp_in_ready_low", {63'd0, in_ready},  64'd0);
        chk("bp_valid",        {63'd0, out_valid}, 64'd1);
        in_valid = 1'b1; in_mode = 3'd1; in_data = 16'h0003;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold_ready", {63'd0, in_ready}, 64'd0);
            chk("bp_hold_data",  {32'd0, out_data}, 64'h00000001);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_ready_back", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_mode = '0; in_data = '0;
        drain();

        // 5: reserved mode then a normal one
        send(3'd6, 16'hABCD);
        send(3'd1, 16'h7FFF);
        drain();

        // 6: asynchronous reset with both entries full
        out_ready = 1'b0;
        send(3'd1, 16'h0011);
        send(3'd1, 16'h0022);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_ready", {63'd0, in_ready},  64'd1);
        sb.delete();
        out_ready = 1'b1;
        @(negedge clk); reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_valid", {63'd0, out_valid}, 64'd0);
            chk("post_rst_ready", {63'd0, in_ready},  64'd1);
        end
        @(posedge clk); #1;
        send(3'd1, 16'h0042);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
